sound_sequencer: RTL and testbench



---
 rtl/bopit_pkg.sv | 19 +
 rtl/sound_sequencer.sv | 75 +++++++
 tb/tb_sound_sequencer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/bopit_pkg.sv
// bopit_pkg: shared sound-select encodings and sequencer state type for the Bop-It datapath
package bopit_pkg;

    localparam logic [1:0] SND_OFF  = 2'b00;
    localparam logic [1:0] SND_BOP  = 2'b01;
    localparam logic [1:0] SND_MISS = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        PLAY_BOP,
        PLAY_MISS,
        GAP
    } snd_state_t;

    function automatic logic [1:0] state_signal(input snd_state_t s);
        return (s == PLAY_BOP) ? SND_BOP : (s == PLAY_MISS) ? SND_MISS : SND_OFF;
    endfunction

endpackage

// File: rtl/sound_sequencer.sv
// sound_sequencer: arbitrates bop/miss effect requests into timed tone + gap sequences
module sound_sequencer
    import bopit_pkg::*;
#(
    parameter int TONE_CYCLES = 5_000_000,
    parameter int GAP_CYCLES  = 1_000_000,
    parameter int CNT_W       = 23
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bop_req,
    input  logic       miss_req,
    input  logic       mute,
    output logic [1:0] signal,
    output logic       busy,
    output logic       done
);

    localparam logic [CNT_W-1:0] TONE_LAST = CNT_W'(TONE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    snd_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bop_pend, miss_pend, bop_d, miss_d;

    // Next state, duration counter and pending flags; miss always wins arbitration
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bop_d   = bop_pend | bop_req;
        miss_d  = miss_pend | miss_req;
        if (mute) begin
            state_d = IDLE;
            cnt_d   = '0;
            bop_d   = 1'b0;
            miss_d  = 1'b0;
        end else if (state_q == IDLE || (state_q == GAP && cnt_q == GAP_LAST)) begin
            cnt_d   = '0;
            state_d = miss_d ? PLAY_MISS : bop_d ? PLAY_BOP : IDLE;
            if (miss_d) miss_d = 1'b0;
            else bop_d = 1'b0;
        end else if (state_q == PLAY_BOP && miss_req) begin
            state_d = PLAY_MISS;
            cnt_d   = '0;
            miss_d  = 1'b0;
        end else if (state_q != GAP && cnt_q == TONE_LAST) begin
            state_d = GAP;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State, counter, flags and registered outputs derived from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bop_pend  <= 1'b0;
            miss_pend <= 1'b0;
            signal    <= SND_OFF;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bop_pend  <= bop_d;
            miss_pend <= miss_d;
            signal    <= state_signal(state_d);
            busy      <= state_d != IDLE;
            done      <= state_d == GAP && cnt_d == GAP_LAST;
        end
    end

endmodule

// File: tb/tb_sound_sequencer.sv
// tb_sound_sequencer: scoreboard bench for sound_sequencer with short tone/gap durations
module tb_sound_sequencer;
    import bopit_pkg::*;

    localparam int TC = 8;
    localparam int GC = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       bop_req = 1'b0;
    logic       miss_req = 1'b0;
    logic       mute = 1'b0;
    logic [1:0] signal;
    logic       busy;
    logic       done;

    sound_sequencer #(.TONE_CYCLES(TC), .GAP_CYCLES(GC), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .bop_req(bop_req), .miss_req(miss_req),
        .mute(mute), .signal(signal), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] sig;
        logic       busy;
        logic       done;
    } obs_t;

    typedef struct {
        logic       bop;
        logic       miss;
        logic [1:0] first;
        logic [1:0] second;
    } vec_t;

    obs_t  exp_q[$];
    vec_t  tbl[4];
    int    total = 0;
    int    bad = 0;
    int    cyc_n = 0;
    string tag = "reset";

    function automatic void push(input logic [1:0] s, input logic b, input logic d, input int n);
        obs_t e;
        e.sig  = s;
        e.busy = b;
        e.done = d;
        for (int i = 0; i < n; i++) exp_q.push_back(e);
    endfunction

    function automatic void push_effect(input logic [1:0] s);
        push(s, 1'b1, 1'b0, TC);
        push(SND_OFF, 1'b1, 1'b0, GC - 1);
        push(SND_OFF, 1'b1, 1'b1, 1);
    endfunction

    task automatic check_now();
        obs_t a, e;
        a = {signal, busy, done};
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s cycle %0d: no expectation queued, got sig=%b busy=%b done=%b",
                     tag, cyc_n, a.sig, a.busy, a.done);
        end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
                bad++;
                $display("FAIL %s cycle %0d: got sig=%b busy=%b done=%b, want sig=%b busy=%b done=%b",
                         tag, cyc_n, a.sig, a.busy, a.done, e.sig, e.busy, e.done);
            end
        end
        cyc_n++;
    endtask

    task automatic cyc(input logic b, input logic m, input logic mu);
        bop_req  = b;
        miss_req = m;
        mute     = mu;
        @(posedge clk);
        #1;
        bop_req  = 1'b0;
        miss_req = 1'b0;
        check_now();
    endtask

    task automatic drain();
        int n;
        n = exp_q.size();
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0);
    endtask

    task automatic scn(input string t);
        tag   = t;
        cyc_n = 0;
    endtask

    initial begin
        tbl[0] = '{bop: 1'b1, miss: 1'b0, first: SND_BOP,  second: SND_OFF};
        tbl[1] = '{bop: 1'b0, miss: 1'b1, first: SND_MISS, second: SND_OFF};
        tbl[2] = '{bop: 1'b1, miss: 1'b1, first: SND_MISS, second: SND_BOP};
        tbl[3] = '{bop: 1'b0, miss: 1'b0, first: SND_OFF,  second: SND_OFF};

        scn("reset");
        #1;
        push(SND_OFF, 1'b0, 1'b0, 1);
        check_now();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        scn("single_bop");
        push(SND_OFF, 1'b0, 1'b0, 9);
        push_effect(SND_BOP);
        push(SND_OFF, 1'b0, 1'b0, 2);
        repeat (9) cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        drain();

        for (int k = 0; k < 4; k++) begin
            scn($sformatf("table%0d", k));
            if (tbl[k].first != SND_OFF) push_effect(tbl[k].first);
            else push(SND_OFF, 1'b0, 1'b0, 3);
            if (tbl[k].second != SND_OFF) push_effect(tbl[k].second);
            push(SND_OFF, 1'b0, 1'b0, 2);
            cyc(tbl[k].bop, tbl[k].miss, 1'b0);
            drain();
        end

        scn("preempt");
        push(SND_BOP, 1'b1, 1'b0, 4);
        push_effect(SND_MISS);
        push(SND_OFF, 1'b0, 1'b0, 2);
        cyc(1'b1, 1'b0, 1'b0);
        repeat (3) cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        drain();

        scn("coalesce");
        push_effect(SND_MISS);
        push_effect(SND_BOP);
        push(SND_OFF, 1'b0, 1'b0, 2);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        drain();

        scn("mute");
        push(SND_MISS, 1'b1, 1'b0, 3);
        push(SND_OFF, 1'b0, 1'b0, 15);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b1);
        drain();

        scn("async_rst");
        push(SND_BOP, 1'b1, 1'b0, TC);
        push(SND_OFF, 1'b1, 1'b0, 2);
        cyc(1'b1, 1'b0, 1'b0);
        repeat (TC - 1) cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        push(SND_OFF, 1'b0, 1'b0, 1);
        check_now();
        @(posedge clk);
        #1;
        push(SND_OFF, 1'b0, 1'b0, 1);
        check_now();
        rst = 1'b0;
        push(SND_OFF, 1'b0, 1'b0, 4);
        drain();
        push_effect(SND_BOP);
        push(SND_OFF, 1'b0, 1'b0, 2);
        cyc(1'b1, 1'b0, 1'b0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
